fifo_wptr_ctrl: RTL and testbench
=================================

// Module: fifo_wptr_ctrl
// PURPOSE
//  Write-side pointer/flag controller for the async FIFO, fully parametrised in depth (2^ADDR_WIDTH).
//  Keeps binary and Gray write pointers, addresses the dual-port RAM and gates writes.
//  Computes registered full, almost-full and occupancy against the Gray read pointer.
//  That read pointer arrives already synchronised into w_clk.
//  Sits in the write clock domain, paired with the read-side pointer block.
// PARAMETERS
//  ADDR_WIDTH    3  RAM address bits; DEPTH = 2^ADDR_WIDTH; pointers are ADDR_WIDTH+1 bits; legal >= 2
//  AFULL_THRESH  6  occupancy at/above which w_afull asserts; legal 1..DEPTH
// PORTS
//  w_clk       in   1             write-domain clock
//  w_rst_n     in   1             async active-low reset (asserts immediately, released by the reset synchroniser)
//  w_inc       in   1             write request
//  sync_r_ptr  in   ADDR_WIDTH+1  Gray read pointer, synchronised to w_clk
//  w_push      out  1             RAM write enable = w_inc & ~w_full (combinational)
//  w_addr      out  ADDR_WIDTH    RAM write address = binary ptr[ADDR_WIDTH-1:0]
//  gray_w_ptr  out  ADDR_WIDTH+1  registered Gray write pointer, to read-side synchroniser
//  w_full      out  1             registered full flag
//  w_afull     out  1             registered almost-full flag
//  w_level     out  ADDR_WIDTH+1  registered occupancy, 0..DEPTH
//  w_ovf_clr   in   1             (WPTR_OVF_FLAG_EN only) clear sticky overflow
//  w_ovf       out  1             (WPTR_OVF_FLAG_EN only) sticky overflow
// BEHAVIOUR
//  Reset (async): binary ptr, gray_w_ptr, w_full, w_afull, w_level and w_ovf all 0.
//  b_nxt = b + w_push (mod 2^(ADDR_WIDTH+1)); g_nxt = b_nxt ^ (b_nxt >> 1).
//  b and gray_w_ptr load on the same edge; Gray never lags binary.
//  Gray is generic XOR logic for any width; no lookup tables.
//  w_full <= (g_nxt == {~sync_r_ptr[MSB:MSB-1], sync_r_ptr[MSB-2:0]}).
//  r_bin = gray2bin(sync_r_ptr); w_level <= b_nxt - r_bin (mod 2^(ADDR_WIDTH+1)).
//  w_afull <= (b_nxt - r_bin) >= AFULL_THRESH.
//  Flag latency: one w_clk after the push.
//  Read-side release: full/afull clear one w_clk after sync_r_ptr advances.
//  This lag is conservative only; a full or afull flag is never late.
//  w_inc while w_full: ignored; w_push = 0, pointers hold, no RAM write.
//  Push with read advance in the same cycle: w_level reflects both; net change 0.
//  Wrap: b rolls 2^(ADDR_WIDTH+1)-1 -> 0; MSB toggle distinguishes full from empty; no special case.
//  Reset mid-operation: all state clears at once.
//  The read side must be reset in the same event, or pointers are inconsistent.
// CONFIGURATION
//  `WPTR_OVF_FLAG_EN defined: adds w_ovf and w_ovf_clr.
//    w_ovf <= 1 on (w_inc & w_full), else 0 on w_ovf_clr, else hold; set wins over clear.
//  Undefined: both ports and the logic are absent; the dropped write is silent.
// STRUCTURE
//  Shared package fifo_pkg: bin2gray/gray2bin functions and FIFO_PTR_W(aw) = aw+1 width helper.
//  The read-pointer block also uses fifo_pkg.
//  One sub-module fifo_gray2bin (parametrised XOR-prefix).
//  It is instantiated here on sync_r_ptr and reused by the read side on its synced write pointer.
// TESTING (ADDR_WIDTH=3, AFULL_THRESH=6)
//  1 Reset, then idle -> gray_w_ptr=0, w_addr=0, w_full=0, w_afull=0, w_level=0.
//  2 8 pushes, sync_r_ptr=0 -> gray 1,3,2,6,7,5,4,C.
//    After push 8: w_full=1, w_level=8, w_addr=0.
//    Push 9: w_push=0 and pointers hold.
//  3 6 pushes -> w_afull=1, w_level=6.
//    Then sync_r_ptr=4'h1 -> next cycle w_level=5, w_afull=0.
//  4 24 pushes, sync_r_ptr tracking 2 behind -> b wraps 15->0, gray C..8->0.
//    w_level stays 2; w_full never asserts.
//  5 OVF_EN: full, then w_inc=1 -> w_ovf=1 next cycle.
//    w_ovf holds until w_ovf_clr; w_inc with w_ovf_clr in the same cycle keeps w_ovf=1.
//  6 Drop w_rst_n mid-clock at w_level=5 -> all outputs 0 before the next edge.
//    The first push after release gives gray_w_ptr=1.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared async-FIFO helpers: pointer width and Gray/binary conversion.
// Used by both the write-side and read-side pointer blocks.
package fifo_pkg;

    function automatic int unsigned FIFO_PTR_W(input int unsigned aw);
        return aw + 1;
    endfunction

    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

    // Each binary bit is the XOR of all Gray bits at and above it
    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b = '0;
        for (int unsigned i = 0; i < 32; i++) begin
            b[i] = ^(g >> i);
        end
        return b;
    endfunction

endpackage

// File: rtl/fifo_gray2bin.sv
// Parametrised Gray-to-binary converter (XOR prefix from the MSB down).
// Shared by the write side (synced read pointer) and the read side.
module fifo_gray2bin #(
    parameter int unsigned W = 4
) (
    input  logic [W-1:0] gray,
    output logic [W-1:0] bin
);

    always_comb begin
        bin = '0;
        for (int unsigned i = 0; i < W; i++) begin
            bin[i] = ^(gray >> i);
        end
    end

endmodule

// File: rtl/fifo_wptr_ctrl.sv
// Async-FIFO write-side pointer and flag controller (w_clk domain).
// Optional sticky overflow flag: define WPTR_OVF_FLAG_EN.
module fifo_wptr_ctrl
    import fifo_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH   = 3,
    parameter int unsigned AFULL_THRESH = 6
) (
    input  logic                                w_clk,
    input  logic                                w_rst_n,
    input  logic                                w_inc,
    input  logic [FIFO_PTR_W(ADDR_WIDTH)-1:0]   sync_r_ptr,
    output logic                                w_push,
    output logic [ADDR_WIDTH-1:0]               w_addr,
    output logic [FIFO_PTR_W(ADDR_WIDTH)-1:0]   gray_w_ptr,
    output logic                                w_full,
    output logic                                w_afull,
    output logic [FIFO_PTR_W(ADDR_WIDTH)-1:0]   w_level
`ifdef WPTR_OVF_FLAG_EN
    ,
    input  logic                                w_ovf_clr,
    output logic                                w_ovf
`endif
);

    localparam int unsigned PW = FIFO_PTR_W(ADDR_WIDTH);

    logic [PW-1:0] b;
    logic [PW-1:0] b_nxt;
    logic [PW-1:0] g_nxt;
    logic [PW-1:0] r_bin;
    logic [PW-1:0] full_cmp;
    logic [PW-1:0] level_nxt;
    logic          afull_nxt;

    fifo_gray2bin #(.W(PW)) u_r_gray2bin (
        .gray (sync_r_ptr),
        .bin  (r_bin)
    );

    // Full when the next write pointer equals the read pointer with its top two Gray bits inverted
    always_comb begin
        w_push    = w_inc & ~w_full;
        b_nxt     = b + PW'(w_push);
        g_nxt     = PW'(bin2gray(32'(b_nxt)));
        full_cmp  = {~sync_r_ptr[PW-1 -: 2], sync_r_ptr[PW-3:0]};
        level_nxt = b_nxt - r_bin;
        afull_nxt = 32'(level_nxt) >= AFULL_THRESH;
    end

    assign w_addr = b[ADDR_WIDTH-1:0];

    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            b          <= '0;
            gray_w_ptr <= '0;
            w_full     <= 1'b0;
            w_afull    <= 1'b0;
            w_level    <= '0;
        end else begin
            b          <= b_nxt;
            gray_w_ptr <= g_nxt;
            w_full     <= (g_nxt == full_cmp);
            w_afull    <= afull_nxt;
            w_level    <= level_nxt;
        end
    end

`ifdef WPTR_OVF_FLAG_EN
    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            w_ovf <= 1'b0;
        end else if (w_inc & w_full) begin
            w_ovf <= 1'b1;
        end else if (w_ovf_clr) begin
            w_ovf <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_fifo_wptr_ctrl.sv
// Self-checking bench for fifo_wptr_ctrl (ADDR_WIDTH=3, AFULL_THRESH=6),
// compared every cycle against an occupancy-count model.
module tb_fifo_wptr_ctrl;

    localparam int AW    = 3;
    localparam int DEPTH = 8;
    localparam int AFT   = 6;

    logic       clk;
    logic       rst_n;
    logic       w_inc;
    logic [3:0] sync_r_ptr;
    logic       w_push;
    logic [2:0] w_addr;
    logic [3:0] gray_w_ptr;
    logic       w_full;
    logic       w_afull;
    logic [3:0] w_level;
`ifdef WPTR_OVF_FLAG_EN
    logic       w_ovf_clr;
    logic       w_ovf;
`endif

    fifo_wptr_ctrl #(.ADDR_WIDTH(AW), .AFULL_THRESH(AFT)) dut (
        .w_clk      (clk),
        .w_rst_n    (rst_n),
        .w_inc      (w_inc),
        .sync_r_ptr (sync_r_ptr),
        .w_push     (w_push),
        .w_addr     (w_addr),
        .gray_w_ptr (gray_w_ptr),
        .w_full     (w_full),
        .w_afull    (w_afull),
        .w_level    (w_level)
`ifdef WPTR_OVF_FLAG_EN
        ,
        .w_ovf_clr  (w_ovf_clr),
        .w_ovf      (w_ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: absolute write/read counts; occupancy is their difference
    int  mw;
    int  rc;
    bit  mfull;
    bit  mafull;
    int  mlevel;
    bit  movf;

    function automatic int gray4(input int v);
        int b;
        b = v % 16;
        return (b ^ (b >> 1)) & 15;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mw = 0; rc = 0; mfull = 0; mafull = 0; mlevel = 0; movf = 0;
    endtask

    task automatic compare_model();
        check("w_addr",  int'(w_addr),     mw % DEPTH);
        check("gray",    int'(gray_w_ptr), gray4(mw));
        check("w_full",  int'(w_full),     int'(mfull));
        check("w_afull", int'(w_afull),    int'(mafull));
        check("w_level", int'(w_level),    mlevel);
`ifdef WPTR_OVF_FLAG_EN
        check("w_ovf",   int'(w_ovf),      int'(movf));
`endif
    endtask

    // One write-clock cycle: drive at negedge, check push, advance model, check after edge
    task automatic step(input bit inc, input int rabs, input bit clr);
        bit push;
        int lvl;
        @(negedge clk);
        w_inc      = inc;
        rc         = rabs;
        sync_r_ptr = 4'(gray4(rabs));
`ifdef WPTR_OVF_FLAG_EN
        w_ovf_clr  = clr;
`endif
        #1;
        push = inc && !mfull;
        check("w_push", int'(w_push), int'(push));
`ifdef WPTR_OVF_FLAG_EN
        if (inc && mfull) movf = 1;
        else if (clr)     movf = 0;
`endif
        mw     = mw + int'(push);
        lvl    = mw - rc;
        mfull  = (lvl == DEPTH);
        mafull = (lvl >= AFT);
        mlevel = lvl;
        @(posedge clk);
        #1;
        compare_model();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; w_inc = 1'b0; sync_r_ptr = '0;
`ifdef WPTR_OVF_FLAG_EN
        w_ovf_clr = 1'b0;
`endif
        repeat (2) @(negedge clk);
        check("rst_gray",  int'(gray_w_ptr), 0);
        check("rst_full",  int'(w_full),     0);
        check("rst_level", int'(w_level),    0);
        rst_n = 1'b1;
        model_reset();
    endtask

    int exp_gray [8] = '{1, 3, 2, 6, 7, 5, 4, 12};

    initial begin
        rst_n = 1'b1; w_inc = 1'b0; sync_r_ptr = '0;
`ifdef WPTR_OVF_FLAG_EN
        w_ovf_clr = 1'b0;
`endif
        model_reset();
        #2 rst_n = 1'b0;

        // Reset then idle
        do_reset();
        repeat (3) step(0, 0, 0);
        check("idle_gray",  int'(gray_w_ptr), 0);
        check("idle_addr",  int'(w_addr),     0);
        check("idle_full",  int'(w_full),     0);
        check("idle_afull", int'(w_afull),    0);
        check("idle_level", int'(w_level),    0);

        // Fill to full, Gray sequence, then a rejected push
        for (int i = 0; i < 8; i++) begin
            step(1, 0, 0);
            check("fill_gray", int'(gray_w_ptr), exp_gray[i]);
        end
        check("full_flag",  int'(w_full),  1);
        check("full_level", int'(w_level), 8);
        check("full_addr",  int'(w_addr),  0);
        @(negedge clk);
        w_inc = 1'b1;
        #1;
        check("full_push", int'(w_push), 0);
        step(1, 0, 0);
        check("hold_gray", int'(gray_w_ptr), 12);
        check("hold_addr", int'(w_addr),     0);

        // Almost-full set and release on read advance
        do_reset();
        repeat (6) step(1, 0, 0);
        check("af_set",    int'(w_afull), 1);
        check("af_level6", int'(w_level), 6);
        step(0, 1, 0);
        check("af_level5", int'(w_level), 5);
        check("af_clear",  int'(w_afull), 0);

        // Push and read advance together: level unchanged
        step(1, 2, 0);
        check("net0_level", int'(w_level), 5);

        // Wrap with read pointer trailing by two
        do_reset();
        step(1, 0, 0);
        step(1, 0, 0);
        for (int i = 0; i < 24; i++) begin
            step(1, mw - 1, 0);
            check("wrap_level", int'(w_level), 2);
            check("wrap_full",  int'(w_full),  0);
        end

`ifdef WPTR_OVF_FLAG_EN
        // Sticky overflow: set, hold, set-wins-over-clear, clear
        do_reset();
        repeat (8) step(1, 0, 0);
        step(1, 0, 0);
        check("ovf_set", int'(w_ovf), 1);
        step(0, 0, 0);
        check("ovf_hold", int'(w_ovf), 1);
        step(1, 0, 1);
        check("ovf_setwins", int'(w_ovf), 1);
        step(0, 0, 1);
        check("ovf_clr", int'(w_ovf), 0);
`endif

        // Randomized traffic with varying read rates
        do_reset();
        for (int ph = 0; ph < 3; ph++) begin
            int p;
            p = (ph == 0) ? 20 : (ph == 1) ? 80 : 50;
            for (int i = 0; i < 300; i++) begin
                int r;
                r = rc;
                if (r < mw && $urandom_range(99) < p) r++;
                step(($urandom_range(99) < 60), r, ($urandom_range(7) == 0));
            end
        end

        // Asynchronous reset mid-cycle at level 5
        do_reset();
        repeat (5) step(1, 0, 0);
        check("pre_rst_level", int'(w_level), 5);
        w_inc = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_gray",  int'(gray_w_ptr), 0);
        check("arst_addr",  int'(w_addr),     0);
        check("arst_full",  int'(w_full),     0);
        check("arst_afull", int'(w_afull),    0);
        check("arst_level", int'(w_level),    0);
`ifdef WPTR_OVF_FLAG_EN
        check("arst_ovf",   int'(w_ovf),      0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        step(1, 0, 0);
        check("post_rst_gray", int'(gray_w_ptr), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
